// File: rtl/pcie_symbols_pkg.sv
// Symbol constants and assembler state shared by the receive ordered-set path.
package pcie_symbols_pkg;

  localparam logic [7:0] COM      = 8'hBC;
  localparam logic [7:0] SKP_K    = 8'h1C;
  localparam logic [7:0] TS1_ID   = 8'h4A;
  localparam logic [7:0] TS2_ID   = 8'h45;
  localparam logic [7:0] GEN3_TS1 = 8'h1E;
  localparam logic [7:0] GEN3_TS2 = 8'h2D;
  localparam logic [7:0] GEN3_SKP = 8'hAA;
  localparam logic [1:0] SYNC_OS  = 2'b01;

  typedef enum logic [1:0] {
    ASM_IDLE,
    ASM_COLLECT,
    ASM_DONE
  } asmState_t;

  // Training-set identity: symbol 6 in 8b/10b, symbol 0 in 128b/130b.
  function automatic logic isTrainingSet(input logic gen3Mode, input logic [7:0] sym0,
                                         input logic [7:0] sym6);
    if (gen3Mode) return (sym0 == GEN3_TS1) || (sym0 == GEN3_TS2);
    return (sym6 == TS1_ID) || (sym6 == TS2_ID);
  endfunction

endpackage

// File: rtl/os_lane_assembler.sv
// Per-lane 16-symbol ordered-set assembler with ready/clear handshake.
// RX_OS_COLLECTOR_TS_FILTER_EN: only TS1/TS2 sets are allowed to complete.
//
// state       | meaning
// ASM_IDLE    | waiting for COM (8b/10b) or an ordered-set block start (128b/130b)
// ASM_COLLECT | storing symbols 1..15 into the collect buffer
// ASM_DONE    | set just handed to the holding register; back to idle next cycle
module os_lane_assembler
  import pcie_symbols_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         gen3Mode,
  input  logic         rxValid,
  input  logic         rxDataK,
  input  logic         rxStartBlock,
  input  logic         clearReady,
  input  logic [7:0]   rxSymbol,
  input  logic [1:0]   rxSyncHeader,
  output logic         ready,
  output logic [127:0] holding
);

  asmState_t    state, nextState;
  logic [3:0]   symIndex;
  logic [127:0] collectBuf;
  logic         startOk, breakSet, setAccepted;
  logic         loadFirst, storeSym, completeSet;

  always_comb begin
    if (gen3Mode) begin
      startOk  = rxValid && rxStartBlock && (rxSyncHeader == SYNC_OS) && (rxSymbol != GEN3_SKP);
      breakSet = rxStartBlock;
    end else begin
      startOk  = rxValid && rxDataK && (rxSymbol == COM);
      // SKP right after COM is itself a K symbol; named separately so the abort reason reads clearly.
      breakSet = rxDataK || (rxDataK && (symIndex == 4'd1) && (rxSymbol == SKP_K));
    end
  end

`ifdef RX_OS_COLLECTOR_TS_FILTER_EN
  assign setAccepted = isTrainingSet(gen3Mode, collectBuf[7:0], collectBuf[55:48]);
`else
  assign setAccepted = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset || flush) state <= ASM_IDLE;
    else                state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      ASM_IDLE:    if (startOk) nextState = ASM_COLLECT;
      ASM_COLLECT: begin
        if (!rxValid)                nextState = ASM_IDLE;
        else if (breakSet)           nextState = startOk ? ASM_COLLECT : ASM_IDLE;
        else if (symIndex == 4'd15)  nextState = setAccepted ? ASM_DONE : ASM_IDLE;
      end
      ASM_DONE:    nextState = ASM_IDLE;
      default:     nextState = ASM_IDLE;
    endcase
  end

  always_comb begin
    loadFirst   = 1'b0;
    storeSym    = 1'b0;
    completeSet = 1'b0;
    case (state)
      ASM_IDLE:    loadFirst = startOk;
      ASM_COLLECT: begin
        if (rxValid) begin
          if (breakSet) begin
            loadFirst = startOk;
          end else begin
            storeSym    = 1'b1;
            completeSet = (symIndex == 4'd15) && setAccepted;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      symIndex   <= 4'd0;
      collectBuf <= '0;
      holding    <= '0;
      ready      <= 1'b0;
    end else begin
      if (loadFirst) begin
        collectBuf[7:0] <= rxSymbol;
        symIndex        <= 4'd1;
      end else if (storeSym) begin
        collectBuf[{symIndex, 3'b000} +: 8] <= rxSymbol;
        symIndex                            <= symIndex + 4'd1;
      end
      if (completeSet && !flush) holding <= {rxSymbol, collectBuf[119:0]};
      // A clear on the same edge as a completion drops that completion.
      if (clearReady || flush) ready <= 1'b0;
      else if (completeSet)    ready <= 1'b1;
    end
  end

endmodule

// File: rtl/rx_os_collector.sv
// Receive ordered-set collector: lane assemblers, skew window and aligned output register.
// RX_OS_COLLECTOR_TS_FILTER_EN (in os_lane_assembler) restricts completion to TS1/TS2.
module rx_os_collector
  import pcie_symbols_pkg::*;
#(
  parameter int LANES    = 16,
  parameter int MAX_SKEW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    gen,
  input  logic [127:0]  rxData,
  input  logic [15:0]   rxDataK,
  input  logic [31:0]   rxSyncHeader,
  input  logic [15:0]   rxStartBlock,
  input  logic [15:0]   rxValid,
  input  logic [4:0]    numberOfDetectedLanes,
  output logic [2047:0] orderedSets,
  output logic          validOrderedSets,
  output logic          skewError
);

  localparam int         SKEW_W     = $clog2(MAX_SKEW + 1);
  localparam logic [4:0] LANE_LIMIT = 5'(LANES);

  logic [2:0]        genQ;
  logic [4:0]        lanesQ;
  logic              cfgChange, gen3Mode;
  logic [4:0]        numLanes;
  logic [15:0]       enableMask, laneReady, enabledReady;
  logic [127:0]      laneHolding [16];
  logic [2047:0]     nextSets;
  logic [SKEW_W-1:0] skewCnt;
  logic              allReady, anyReady, skewExpired;
  logic              fireValid, fireSkew, clearAll;

  assign gen3Mode  = (gen == 3'd3);
  assign cfgChange = (gen != genQ) || (numberOfDetectedLanes != lanesQ);
  assign numLanes  = (numberOfDetectedLanes > LANE_LIMIT) ? LANE_LIMIT : numberOfDetectedLanes;

  always_comb begin
    enableMask = '0;
    for (int i = 0; i < 16; i++) enableMask[i] = (5'(i) < numLanes);
  end

  for (genvar i = 0; i < 16; i++) begin : gLane
    if (i < LANES) begin : gAsm
      os_lane_assembler uAsm (
        .clk          (clk),
        .reset        (reset),
        .flush        (cfgChange),
        .gen3Mode     (gen3Mode),
        .rxValid      (rxValid[i]),
        .rxDataK      (rxDataK[i]),
        .rxStartBlock (rxStartBlock[i]),
        .clearReady   (clearAll),
        .rxSymbol     (rxData[8*i +: 8]),
        .rxSyncHeader (rxSyncHeader[2*i +: 2]),
        .ready        (laneReady[i]),
        .holding      (laneHolding[i])
      );
    end else begin : gTie
      assign laneReady[i]   = 1'b0;
      assign laneHolding[i] = '0;
    end
  end

  assign enabledReady = laneReady & enableMask;
  assign allReady     = (numLanes != 5'd0) && (enabledReady == enableMask);
  assign anyReady     = |enabledReady;
  assign skewExpired  = anyReady && (skewCnt == SKEW_W'(MAX_SKEW));
  // Completion beats expiry on the same edge; a config change suppresses both strobes.
  assign fireValid    = !cfgChange && allReady;
  assign fireSkew     = !cfgChange && !allReady && skewExpired;
  assign clearAll     = cfgChange || fireValid || fireSkew || (numLanes == 5'd0);

  always_comb begin
    nextSets = '0;
    for (int i = 0; i < 16; i++) nextSets[128*i +: 128] = enableMask[i] ? laneHolding[i] : 128'd0;
  end

  always_ff @(posedge clk) begin
    genQ   <= gen;
    lanesQ <= numberOfDetectedLanes;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      orderedSets      <= '0;
      validOrderedSets <= 1'b0;
      skewError        <= 1'b0;
      skewCnt          <= '0;
    end else begin
      validOrderedSets <= fireValid;
      skewError        <= fireSkew;
      if (fireValid) orderedSets <= nextSets;
      if (clearAll || !anyReady) skewCnt <= '0;
      else if (!skewExpired)     skewCnt <= skewCnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_rx_os_collector.sv
// Randomized bench: per-lane symbol tables, outcome predicted from set start times and the skew rule.
module tb_rx_os_collector;

  localparam int T        = 64;
  localparam int MAX_SKEW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    gen;
  logic [127:0]  rxData;
  logic [15:0]   rxDataK;
  logic [31:0]   rxSyncHeader;
  logic [15:0]   rxStartBlock;
  logic [15:0]   rxValid;
  logic [4:0]    numberOfDetectedLanes;
  logic [2047:0] orderedSets;
  logic          validOrderedSets;
  logic          skewError;

  rx_os_collector dut (
    .clk                   (clk),
    .reset                 (reset),
    .gen                   (gen),
    .rxData                (rxData),
    .rxDataK               (rxDataK),
    .rxSyncHeader          (rxSyncHeader),
    .rxStartBlock          (rxStartBlock),
    .rxValid               (rxValid),
    .numberOfDetectedLanes (numberOfDetectedLanes),
    .orderedSets           (orderedSets),
    .validOrderedSets      (validOrderedSets),
    .skewError             (skewError)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0]   stimSym   [16][T];
  bit           stimK     [16][T];
  bit           stimValid [16][T];
  bit           stimSb    [16][T];
  logic [1:0]   stimHdr   [16][T];
  bit           stimReset [T];
  int           compl     [16];
  logic [127:0] laneSet   [16];
  logic [127:0] expOs     [16];
  logic [127:0] nextOs    [16];

  task automatic checkEq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit setAccepted(input bit g3, input logic [127:0] s);
    bit ok = 1'b1;
`ifdef RX_OS_COLLECTOR_TS_FILTER_EN
    ok = g3 ? (s[7:0] == 8'h1E || s[7:0] == 8'h2D) : (s[55:48] == 8'h4A || s[55:48] == 8'h45);
`endif
    return ok;
  endfunction

  task automatic clearStim(input bit g3);
    for (int l = 0; l < 16; l++) begin
      compl[l]   = -1;
      laneSet[l] = '0;
      for (int t = 0; t < T; t++) begin
        stimSym[l][t]   = 8'($urandom);
        stimK[l][t]     = g3 ? bit'($urandom_range(0, 1)) : 1'b0;
        stimValid[l][t] = 1'b1;
        stimSb[l][t]    = 1'b0;
        stimHdr[l][t]   = g3 ? 2'($urandom) : 2'b00;
      end
    end
    for (int t = 0; t < T; t++) stimReset[t] = 1'b0;
  endtask

  // Writes a complete 16-symbol set on one lane and records when (if ever) it should complete.
  task automatic placeSet(input int lane, input int start, input bit g3, input logic [7:0] key);
    logic [127:0] s;
    logic [7:0]   v;
    s = '0;
    for (int k = 0; k < 16; k++) begin
      v = 8'($urandom);
      if (k == 0) v = g3 ? key : 8'hBC;
      if (!g3 && k == 6) v = key;
      s[8*k +: 8]              = v;
      stimSym[lane][start+k]   = v;
      stimValid[lane][start+k] = 1'b1;
      stimK[lane][start+k]     = g3 ? bit'($urandom_range(0, 1)) : (k == 0);
      stimSb[lane][start+k]    = g3 && (k == 0);
      stimHdr[lane][start+k]   = (g3 && k == 0) ? 2'b01 : 2'b00;
    end
    laneSet[lane] = s;
    if (g3 && key == 8'hAA)      compl[lane] = -1;
    else if (setAccepted(g3, s)) compl[lane] = start + 15;
    else                         compl[lane] = -1;
  endtask

  // evType: 0 nothing, 1 valid, 2 skew error; evCycle is the loop iteration where it is visible.
  task automatic predict(input logic [4:0] n, output int evCycle, output int evType);
    int  en, first, last;
    bit  allDone;
    en      = (n > 16) ? 16 : int'(n);
    evType  = 0;
    evCycle = -1;
    first   = 1 << 20;
    last    = -1;
    allDone = 1'b1;
    for (int l = 0; l < en; l++) begin
      if (compl[l] < 0) allDone = 1'b0;
      else begin
        if (compl[l] < first) first = compl[l];
        if (compl[l] > last)  last  = compl[l];
      end
    end
    if (en == 0 || last < 0) return;
    if (allDone && (last - first) <= MAX_SKEW) begin
      evType  = 1;
      evCycle = last + 2;
      for (int l = 0; l < 16; l++) nextOs[l] = (l < en) ? laneSet[l] : 128'd0;
    end else begin
      evType  = 2;
      evCycle = first + MAX_SKEW + 2;
    end
  endtask

  task automatic driveCycle(input int c, input logic [2:0] g, input logic [4:0] n);
    gen                   = g;
    numberOfDetectedLanes = n;
    reset                 = stimReset[c];
    for (int l = 0; l < 16; l++) begin
      rxData[8*l +: 8]       = stimSym[l][c];
      rxDataK[l]             = stimK[l][c];
      rxValid[l]             = stimValid[l][c];
      rxStartBlock[l]        = stimSb[l][c];
      rxSyncHeader[2*l +: 2] = stimHdr[l][c];
    end
  endtask

  task automatic runScenario(input string name, input logic [2:0] g, input logic [4:0] n);
    int evCycle, evType;
    predict(n, evCycle, evType);
    for (int c = 0; c < T; c++) begin
      @(negedge clk);
      if (c > 0 && stimReset[c-1]) for (int l = 0; l < 16; l++) expOs[l] = '0;
      if (evType == 1 && c == evCycle) for (int l = 0; l < 16; l++) expOs[l] = nextOs[l];
      checkEq($sformatf("%s valid c%0d", name, c), 128'(validOrderedSets),
              128'(evType == 1 && c == evCycle));
      checkEq($sformatf("%s skewError c%0d", name, c), 128'(skewError),
              128'(evType == 2 && c == evCycle));
      for (int l = 0; l < 16; l++)
        checkEq($sformatf("%s lane%0d c%0d", name, l, c), orderedSets[128*l +: 128], expOs[l]);
      driveCycle(c, g, n);
    end
  endtask

  initial begin
    int g, n, s;
    logic [7:0] key;
    reset = 1'b1;
    gen = 3'd1;
    numberOfDetectedLanes = 5'd4;
    rxData = '0;
    rxDataK = '0;
    rxSyncHeader = '0;
    rxStartBlock = '0;
    rxValid = '0;
    for (int l = 0; l < 16; l++) expOs[l] = '0;
    repeat (3) @(negedge clk);
    checkEq("reset valid", 128'(validOrderedSets), 128'd0);
    checkEq("reset skewError", 128'(skewError), 128'd0);
    for (int l = 0; l < 16; l++)
      checkEq($sformatf("reset lane%0d", l), orderedSets[128*l +: 128], 128'd0);

    clearStim(1'b0);
    for (int l = 0; l < 16; l++) placeSet(l, 4, 1'b0, 8'h4A);
    runScenario("g1_aligned", 3'd1, 5'd4);

    clearStim(1'b0);
    for (int l = 0; l < 3; l++) placeSet(l, 4, 1'b0, 8'h4A);
    placeSet(3, 9, 1'b0, 8'h45);
    runScenario("g1_lag5", 3'd1, 5'd4);

    clearStim(1'b0);
    for (int l = 0; l < 3; l++) placeSet(l, 4, 1'b0, 8'h4A);
    placeSet(3, 12, 1'b0, 8'h4A);
    runScenario("g1_lag8", 3'd1, 5'd4);

    clearStim(1'b0);
    for (int l = 0; l < 3; l++) placeSet(l, 4, 1'b0, 8'h4A);
    placeSet(3, 13, 1'b0, 8'h4A);
    runScenario("g1_lag9", 3'd1, 5'd4);

    clearStim(1'b0);
    placeSet(0, 4, 1'b0, 8'h4A);
    stimSym[1][4] = 8'hBC;
    stimK[1][4]   = 1'b1;
    stimSym[1][5] = 8'h1C;
    stimK[1][5]   = 1'b1;
    runScenario("g1_skp_abort", 3'd1, 5'd2);

    clearStim(1'b0);
    for (int l = 0; l < 4; l++) placeSet(l, 4, 1'b0, 8'h45);
    placeSet(2, 11, 1'b0, 8'h45);
    runScenario("g1_com_restart", 3'd1, 5'd4);

    clearStim(1'b1);
    for (int l = 0; l < 16; l++) placeSet(l, 4 + $urandom_range(0, 8), 1'b1, 8'h2D);
    runScenario("g3_ts2", 3'd3, 5'd16);

    clearStim(1'b1);
    for (int l = 0; l < 16; l++) placeSet(l, 4, 1'b1, 8'hAA);
    runScenario("g3_skp_block", 3'd3, 5'd16);

    clearStim(1'b0);
    for (int l = 0; l < 16; l++) placeSet(l, 3 + $urandom_range(0, 2), 1'b0, 8'h45);
    runScenario("g2_clamp20", 3'd2, 5'd20);

    clearStim(1'b0);
    for (int l = 0; l < 4; l++) placeSet(l, 4, 1'b0, 8'h4A);
    stimReset[14] = 1'b1;
    for (int l = 0; l < 4; l++) placeSet(l, 17, 1'b0, 8'h4A);
    runScenario("g1_reset_mid", 3'd1, 5'd4);

    clearStim(1'b0);
    for (int l = 0; l < 4; l++) placeSet(l, 4, 1'b0, 8'h00);
    runScenario("g1_non_ts", 3'd1, 5'd4);

    clearStim(1'b0);
    for (int l = 0; l < 16; l++) placeSet(l, 4, 1'b0, 8'h4A);
    runScenario("g1_n0", 3'd1, 5'd0);

    repeat (12) begin
      g = $urandom_range(1, 3);
      n = $urandom_range(0, 20);
      s = $urandom_range(2, 8);
      clearStim(g == 3);
      for (int l = 0; l < 16; l++) begin
        if ($urandom_range(0, 15) != 0) begin
          if (g == 3) key = ($urandom_range(0, 1) != 0) ? 8'h1E : 8'h2D;
          else        key = ($urandom_range(0, 1) != 0) ? 8'h4A : 8'h45;
          placeSet(l, s + $urandom_range(0, 9), g == 3, key);
        end
      end
      runScenario($sformatf("rand_g%0d_n%0d", g, n), 3'(g), 5'(n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
